// File: rtl/div_job_sequencer.sv
// div_job_sequencer: FIFO-buffered issuer for a multi-cycle divider with result capture,
// divide-by-zero flagging and a WAIT-state timeout.
module div_job_sequencer #(
    parameter int W       = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_dividend,
    input  logic [W-1:0]               in_divisor,
    output logic                       div_go,
    output logic [W-1:0]               div_dividend,
    output logic [W-1:0]               div_divisor,
    input  logic                       div_result_valid,
    input  logic [W-1:0]               div_quotient,
    input  logic [W-1:0]               div_remainder,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_quotient,
    output logic [W-1:0]               out_remainder,
    output logic                       out_div_by_zero,
    output logic                       out_error,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t            state_q, state_d;
    logic [2*W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]     rd_q, wr_q;
    logic [CW-1:0]     count_q;
    logic [W-1:0]      opa_q, opb_q, quo_q, rem_q;
    logic [TW-1:0]     tmo_q;
    logic              dbz_q, out_dbz_q, err_q, ov_q;
    logic              push, pop, done_ok, done_to;
    logic [W-1:0]      head_a, head_b;

    assign {head_a, head_b} = mem_q[rd_q];
    assign in_ready         = count_q != CW'(DEPTH);
    assign push             = in_valid && in_ready;
    assign pop              = state_q == ISSUE;
    assign done_ok          = state_q == WAIT && div_result_valid;
    assign done_to          = state_q == WAIT && !div_result_valid && tmo_q == TW'(TIMEOUT - 1);
    // Operands come straight from the FIFO head during ISSUE, then from the held copy.
    assign div_go           = pop;
    assign div_dividend     = pop ? head_a : opa_q;
    assign div_divisor      = pop ? head_b : opb_q;
    assign out_valid        = ov_q;
    assign out_quotient     = quo_q;
    assign out_remainder    = rem_q;
    assign out_div_by_zero  = out_dbz_q;
    assign out_error        = err_q;
    assign busy             = state_q != IDLE || count_q != '0;
    assign fifo_count       = count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (done_ok || done_to) state_d = OUT;
            OUT:     if (out_ready) state_d = count_q != '0 ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (push) mem_q[wr_q] <= {in_dividend, in_divisor};
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            dbz_q     <= 1'b0;
            tmo_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            out_dbz_q <= 1'b0;
            err_q     <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_q + CW'(push) - CW'(pop);
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) begin
                rd_q  <= rd_q + AW'(1);
                opa_q <= head_a;
                opb_q <= head_b;
                dbz_q <= head_b == '0;
                tmo_q <= '0;
            end
            if (state_q == WAIT) tmo_q <= tmo_q + TW'(1);
            if (done_ok || done_to) begin
                quo_q     <= done_ok ? div_quotient : '0;
                rem_q     <= done_ok ? div_remainder : '0;
                out_dbz_q <= dbz_q;
                err_q     <= done_to;
                ov_q      <= 1'b1;
            end
            if (state_q == OUT && out_ready) ov_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_div_job_sequencer.sv
// tb_div_job_sequencer: directed vectors against a behavioural divider stub; results are
// checked in order by a scoreboard plus hand-written latency/handshake sequences.
module tb_div_job_sequencer;
    typedef struct {
        logic [3:0] a, b, q, r;
        logic       dbz, err;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b1, stall = 1'b0;
    logic [3:0] in_dividend = '0, in_divisor = '0;
    logic       in_ready, div_go, out_valid, out_div_by_zero, out_error, busy;
    logic [3:0] div_dividend, div_divisor, out_quotient, out_remainder;
    logic       rv;
    logic [3:0] qq, rr, sa, sd;
    logic [2:0] scnt;
    logic [2:0] fifo_count;
    int         n_vec = 0, n_err = 0;
    vec_t       tv [9];
    vec_t       sb [$];
    vec_t       e;

    always #5 clk = ~clk;

    div_job_sequencer dut (
        .Clock(clk), .Resetn(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .div_go(div_go), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_result_valid(rv), .div_quotient(qq), .div_remainder(rr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_div_by_zero(out_div_by_zero), .out_error(out_error),
        .busy(busy), .fifo_count(fifo_count)
    );

    // Divider stand-in: result valid 6 cycles after the Go cycle, dropped on Go.
    always @(posedge clk) begin
        if (!rst_n) begin
            rv   <= 1'b0;
            scnt <= '0;
        end else if (div_go) begin
            rv   <= 1'b0;
            scnt <= 3'd5;
            sa   <= div_dividend;
            sd   <= div_divisor;
        end else if (scnt != 0) begin
            scnt <= scnt - 3'd1;
            if (scnt == 3'd1 && !stall) begin
                rv <= 1'b1;
                qq <= sd == 0 ? 4'hF : sa / sd;
                rr <= sd == 0 ? sa : sa % sd;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got q=%0h r=%0h with nothing expected", out_quotient, out_remainder);
            end else begin
                e = sb.pop_front();
                check("result{q,r,dbz,err}", {22'd0, out_quotient, out_remainder, out_div_by_zero, out_error},
                      {22'd0, e.q, e.r, e.dbz, e.err});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input vec_t v);
        int n = 0;
        in_valid = 1'b1;
        in_dividend = v.a;
        in_divisor = v.b;
        while (!in_ready && n < 200) begin step(); n++; end
        if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
        else begin
            sb.push_back(v);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_go(output int n);
        n = 0;
        while (!div_go && n < 60) begin step(); n++; end
        if (!div_go) check("wait_go_timeout", 32'(div_go), 32'd1);
    endtask

    task automatic wait_ov(output int n);
        n = 0;
        while (!out_valid && n < 60) begin step(); n++; end
        if (!out_valid) check("wait_out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin step(); n++; end
        check("drain_remaining", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n, gos;
        tv[0] = '{4'd13, 4'd4, 4'd3,  4'd1, 1'b0, 1'b0};
        tv[1] = '{4'd7,  4'd0, 4'hF,  4'd7, 1'b1, 1'b0};
        tv[2] = '{4'd15, 4'd1, 4'hF,  4'd0, 1'b0, 1'b0};
        tv[3] = '{4'd9,  4'd3, 4'd3,  4'd0, 1'b0, 1'b0};
        tv[4] = '{4'd8,  4'd5, 4'd1,  4'd3, 1'b0, 1'b0};
        tv[5] = '{4'd0,  4'd2, 4'd0,  4'd0, 1'b0, 1'b0};
        tv[6] = '{4'd14, 4'd7, 4'd2,  4'd0, 1'b0, 1'b0};
        tv[7] = '{4'd11, 4'd2, 4'd0,  4'd0, 1'b0, 1'b1};
        tv[8] = '{4'd6,  4'd4, 4'd1,  4'd2, 1'b0, 1'b0};

        repeat (3) step();
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_div_go", 32'(div_go), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", {24'd0, out_quotient, out_remainder}, 32'd0);
        check("rst_flags", {30'd0, out_div_by_zero, out_error}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);

        for (int i = 0; i < 2; i++) begin
            push(tv[i]);
            wait_go(n);
            step();
            check("go_single_pulse", 32'(div_go), 32'd0);
            check("operands_held", {24'd0, div_dividend, div_divisor}, {24'd0, tv[i].a, tv[i].b});
            wait_ov(n);
            check("issue_to_out_valid", 32'(n + 1), 32'd7);
            step();
            check("out_valid_cleared", 32'(out_valid), 32'd0);
        end

        out_ready = 1'b0;
        push(tv[0]);
        wait_go(n);
        wait_ov(n);
        for (int i = 2; i < 6; i++) begin
            push(tv[i]);
            check("fill_count", 32'(fifo_count), 32'(i - 1));
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_dividend = tv[6].a;
        in_divisor = tv[6].b;
        for (int i = 0; i < 3; i++) begin
            step();
            check("pending_count", 32'(fifo_count), 32'd4);
            check("pending_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        push(tv[6]);
        check("refill_count", 32'(fifo_count), 32'd4);
        drain();
        step();
        check("drained_busy", 32'(busy), 32'd0);
        check("drained_count", 32'(fifo_count), 32'd0);

        stall = 1'b1;
        push(tv[7]);
        push(tv[8]);
        wait_go(n);
        wait_ov(n);
        stall = 1'b0;
        check("timeout_latency", 32'(n), 32'd16);
        check("timeout_error", 32'(out_error), 32'd1);
        drain();

        out_ready = 1'b0;
        push(tv[0]);
        wait_go(n);
        wait_ov(n);
        push(tv[3]);
        push(tv[4]);
        push(tv[5]);
        check("depth_minus1_count", 32'(fifo_count), 32'd3);
        out_ready = 1'b1;
        step();
        check("out_to_issue", 32'(div_go), 32'd1);
        push(tv[6]);
        check("push_pop_same_cycle", 32'(fifo_count), 32'd3);
        drain();

        push(tv[0]);
        push(tv[1]);
        push(tv[2]);
        step();
        check("pre_reset_count", 32'(fifo_count), 32'd2);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(fifo_count), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_div_go", 32'(div_go), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        gos = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (div_go) gos++;
        end
        check("no_go_after_reset", 32'(gos), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/div_job_sequencer.md
Name: div_job_sequencer

Overview:
- Upstream feeder and downstream collector for the 4-bit restoring divider.
- Buffers operand pairs in a small FIFO and issues them one at a time to the divider via Go/Divisor/Dividend.
- Holds operands stable until ResultValid, then captures Quotient/Remainder into an output register with a valid/ready handshake.
- Flags divide-by-zero and divider timeout.

Parameters:
- W, 4, operand/result width; must match the divider.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TIMEOUT, 15, maximum cycles in WAIT before error; ≥7.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset. Top level drives the divider's synchronous active-high Reset with ~Resetn.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO not full.
- in_dividend  in  W  dividend.
- in_divisor  in  W  divisor.
- div_go  out  1  to divider Go.
- div_dividend  out  W  to divider Dividend.
- div_divisor  out  W  to divider Divisor.
- div_result_valid  in  1  from divider ResultValid.
- div_quotient  in  W  from divider Quotient.
- div_remainder  in  W  from divider Remainder.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- out_quotient  out  W  captured quotient.
- out_remainder  out  W  captured remainder.
- out_div_by_zero  out  1  captured job had divisor 0.
- out_error  out  1  captured job timed out; quotient/remainder are 0.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, Resetn=0) clears:
  - FIFO pointers and count; FSM to IDLE; operand register; all output registers.
  - Resulting values: in_ready=1, div_go=0, out_valid=0, out_* data=0, busy=0, fifo_count=0.
  - Reset asserted mid-job abandons the job. The divider is reset in the same cycle via ~Resetn.
- FIFO:
  - Push when in_valid && in_ready. in_ready = (count != DEPTH).
  - Pop only in ISSUE; pop never occurs when empty.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - A push into an empty FIFO is not visible to the FSM until the next cycle (no bypass).
- FSM (registered state):
  - IDLE: if FIFO non-empty, go to ISSUE.
  - ISSUE, 1 cycle:
    - Load operand register from FIFO head and pop.
    - div_go=1 combinationally for this cycle only.
    - div_dividend/div_divisor are driven from the FIFO head this cycle and from the operand register afterwards, so they are stable from ISSUE until leaving WAIT.
    - Latch dbz = (divisor==0).
    - Go to WAIT.
  - WAIT:
    - Timeout counter starts at 0 and increments each cycle.
    - If div_result_valid=1: capture div_quotient, div_remainder, and dbz; set out_error=0; set out_valid=1; go to OUT.
    - Else if counter == TIMEOUT-1: set out_quotient=0, out_remainder=0, out_error=1, out_valid=1; go to OUT.
    - A stale ResultValid from a previous job is impossible here: the divider drops ResultValid on the edge that samples Go.
  - OUT:
    - out_valid=1; outputs held stable until out_ready=1.
    - On out_ready: clear out_valid. If FIFO non-empty go to ISSUE directly (no IDLE bubble), else go to IDLE.
- Latency:
  - ISSUE cycle at t gives div_result_valid at t+6 and out_valid at t+7.
  - Sustained throughput is one job per 8 cycles when out_ready is held at 1.
- Divide by zero:
  - The job is still issued.
  - The divider naturally returns Q=all-ones and R=dividend; these values are passed through with out_div_by_zero=1.
- busy = (state != IDLE) || (count != 0).

Test Plan:
- Reset, push 13/4, out_ready=1 → div_go pulse 1 cycle; out_valid 7 cycles after ISSUE; Q=3, R=1, dbz=0, err=0.
- Push 7/0 → Q=4'hF, R=7, out_div_by_zero=1.
- Push 5 jobs back-to-back (15/1, 9/3, 8/5, 0/2, 14/7) with out_ready=0:
  - in_ready drops after 4 stored, with the 5th held pending.
  - Release out_ready → results in order (F/0, 3/0, 1/3, 0/0, 2/0).
  - fifo_count tracks correctly through pointer wrap.
- Divider stub holding div_result_valid=0 → out_error=1 and Q=R=0 exactly TIMEOUT cycles after entering WAIT; the next queued job then proceeds normally.
- Assert Resetn=0 during WAIT with 2 jobs queued → all outputs at reset values immediately (async), fifo_count=0, no further div_go after release.
- Simultaneous push and OUT→ISSUE pop at count=DEPTH-1 → count unchanged, data order preserved.
